ps2_rx_packet_funcmod: RTL and testbench
========================================

Name: ps2_rx_packet_funcmod

Overview:
Parametrised PS/2 device-to-host packet receiver. Replaces the fixed 3/4-byte mouse read function.
- Captures a runtime-selectable number of bytes per packet, from 1 to MAX_BYTES.
- Checks start, parity and stop bits, and recovers from lost sync with an inactivity timeout.
- Sits between the PS/2 pins and the mouse/keyboard control layer, which consumes the oTrig/oData/oErr outputs.

Parameters:
MAX_BYTES, 4, maximum bytes per packet; oData width is 8*MAX_BYTES.
TIMEOUT_CYC, 100000, CLOCK cycles without a PS2_CLK falling edge before a partial packet is aborted (2 ms at 50 MHz).
DEGLITCH_CYC, 8, consecutive stable samples required by the optional clock filter.

Ports:
CLOCK  in  1  system clock; all logic rises on this edge.
RESET  in  1  synchronous, active-high reset.
PS2_CLK  in  1  raw PS/2 clock pin, asynchronous.
PS2_DAT  in  1  raw PS/2 data pin, asynchronous.
iEn  in  1  receive enable; low forces abort and idle.
iLen  in  $clog2(MAX_BYTES+1)  bytes per packet; sampled at the first start bit of each packet.
oTrig  out  1  one-cycle pulse: packet complete, oData valid.
oData  out  8*MAX_BYTES  packet; byte k at [8k+7:8k], first received byte lowest.
oErr  out  2  one-cycle error code: 00 none, 01 parity, 10 frame, 11 timeout.

Behaviour:
- Clock/reset: one clock, CLOCK. RESET is synchronous and active-high. RESET has priority over all other events.
- Reset values: oTrig=0, oData=0, oErr=00, state=IDLE, byte count=0, timeout counter=0, synchroniser flops=1.
- Input conditioning:
  - PS2_CLK and PS2_DAT each pass through a 2-flop synchroniser.
  - isH2L = previous synchronised clock is 1 and current is 0.
  - Data is sampled from the synchronised PS2_DAT in the isH2L cycle.
- FSM states: IDLE, DATA (8 bits, LSB first), PARITY, STOP, DONE.
  - IDLE:
    - isH2L with DAT=0: start bit accepted, go to DATA.
    - If byte count is 0, latch the effective length: iLen clamped; 0 or >MAX_BYTES becomes MAX_BYTES.
    - isH2L with DAT=1: ignored; stay in IDLE.
  - DATA: shift one bit per isH2L, LSB first; after the 8th bit go to PARITY.
  - PARITY: capture the parity bit. Odd parity required: XOR of the 8 data bits and the parity bit must equal 1.
  - STOP, on isH2L:
    - DAT=0: frame error.
    - Parity failed: parity error. If both faults occur, parity is reported.
    - Otherwise store the byte in slot[count] and increment count.
    - If count now equals the latched length, go to DONE; else go to IDLE and wait for the next byte.
  - DONE (one cycle):
    - Load oData from the slots; slots at or above the length are zero.
    - oTrig=1, clear count, go to IDLE.
    - oTrig rises exactly 1 cycle after the stop-bit isH2L cycle.
- oData holds its value between oTrig pulses; it changes only in the oTrig cycle.
- Errors:
  - oErr pulses for one cycle, the cycle after detection.
  - The partial packet is discarded: count=0, state=IDLE, oData unchanged, no oTrig.
- Timeout:
  - Counter runs whenever state is not IDLE, or count is not 0. It clears on every isH2L.
  - On reaching TIMEOUT_CYC-1: oErr=11 and abort as above.
  - isH2L in the same cycle as expiry: the edge wins and the counter clears.
- iEn low:
  - Immediate abort to IDLE with count=0 and no oErr.
  - Edges are ignored while low.
  - iEn low takes priority over isH2L in the same cycle.
- oTrig and a nonzero oErr are never high in the same cycle.

Optional Feature:
PS2_DEGLITCH_EN
- Defined: after the synchroniser, the clock level changes only after DEGLITCH_CYC consecutive identical samples. Pulses shorter than this are rejected. Adds DEGLITCH_CYC cycles of edge latency.
- Undefined: plain 2-flop synchroniser; a single-cycle glitch produces an edge.

Decomposition:
- Package ps2_pkg holds:
  - oErr code constants (ERR_NONE, ERR_PARITY, ERR_FRAME, ERR_TIMEOUT).
  - FSM state encoding.
  - Default TIMEOUT_CYC.
- Sub-module ps2_edge_sync holds the synchroniser, the optional deglitch filter and isH2L generation. The FSM, slots and timeout stay in the top module.

Test Plan:
- iLen=3; frames 0x08, 0x10, 0xF0 with correct parity -> single oTrig 1 cycle after the 3rd stop edge; oData=32'h00F01008; oErr stays 00.
- iLen=4; frames 0x08, 0x01, 0xFF, 0x01 -> oData=32'h01FF0108. Then iLen=0 -> clamps to 4 bytes.
- Byte 2 sent with wrong parity bit -> oErr=01 for 1 cycle, no oTrig. Next clean 3-byte packet -> correct oTrig/oData.
- 5 data bits then clock idle -> oErr=11 exactly TIMEOUT_CYC cycles after the last edge. State returns to IDLE and the next packet is received cleanly.
- Stop bit driven 0 -> oErr=10. iEn dropped mid-byte -> no oErr, no oTrig; after re-enable a full packet is received.
- With PS2_DEGLITCH_EN: a 2-cycle low glitch on PS2_CLK is ignored. Without it: the same glitch shifts a bit and a parity or frame error is reported.

Source files
------------

// File: rtl/ps2_pkg.sv
// ---------------------------------------------------------------------------
// ps2_pkg
// Shared definitions for the PS/2 packet receiver:
//   - oErr code values reported to the control layer
//   - receive FSM state encoding
//   - default inactivity timeout (2 ms at 50 MHz)
//   - odd-parity helper used by the frame checker
// ---------------------------------------------------------------------------
package ps2_pkg;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_PARITY  = 2'b01;
    localparam logic [1:0] ERR_FRAME   = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_DONE
    } state_t;

    localparam int TIMEOUT_CYC_DEFAULT = 100000;

    // PS/2 uses odd parity: data bits plus parity bit hold an odd number of ones.
    function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction

endpackage

// File: rtl/ps2_edge_sync.sv
// ---------------------------------------------------------------------------
// ps2_edge_sync
// Brings the asynchronous PS/2 clock and data pins into the CLOCK domain and
// flags the falling edges of the PS/2 clock.
//
// Optional build macro: PS2_DEGLITCH_EN
//   defined   - the synchronised PS/2 clock only changes level after
//               DEGLITCH_CYC consecutive identical samples (short pulses are
//               dropped, edge latency grows by DEGLITCH_CYC cycles)
//   undefined - plain two-flop synchroniser
//
// Ports:
//   clk       in   system clock
//   rst       in   synchronous active-high reset
//   ps2_clk   in   raw PS/2 clock pin
//   ps2_dat   in   raw PS/2 data pin
//   is_h2l    out  one-cycle flag: PS/2 clock went high-to-low
//   dat_sync  out  synchronised PS/2 data level
// ---------------------------------------------------------------------------
module ps2_edge_sync #(
    parameter int DEGLITCH_CYC = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic ps2_clk,
    input  logic ps2_dat,
    output logic is_h2l,
    output logic dat_sync
);

    if (DEGLITCH_CYC < 1) begin : g_bad_deglitch
        $error("DEGLITCH_CYC must be at least 1");
    end

    logic clk_sync_p0;
    logic clk_sync_p1;
    logic dat_sync_p0;
    logic dat_sync_p1;
    logic clk_lvl;
    logic clk_prev;

    // Stage p0 -> p1: two-flop synchronisers; the idle bus level is high.
    always_ff @(posedge clk) begin
        if (rst) begin
            clk_sync_p0 <= 1'b1;
            clk_sync_p1 <= 1'b1;
            dat_sync_p0 <= 1'b1;
            dat_sync_p1 <= 1'b1;
        end else begin
            clk_sync_p0 <= ps2_clk;
            clk_sync_p1 <= clk_sync_p0;
            dat_sync_p0 <= ps2_dat;
            dat_sync_p1 <= dat_sync_p0;
        end
    end

`ifdef PS2_DEGLITCH_EN
    localparam int DG_W = $clog2(DEGLITCH_CYC + 1);
    localparam logic [DG_W-1:0] DG_LAST = DG_W'(DEGLITCH_CYC - 1);

    logic            clk_filt;
    logic [DG_W-1:0] dg_cnt;

    // Filter stage: count samples that disagree with the current level and
    // restart the count as soon as one agrees again.
    always_ff @(posedge clk) begin
        if (rst) begin
            clk_filt <= 1'b1;
            dg_cnt   <= '0;
        end else if (clk_sync_p1 == clk_filt) begin
            dg_cnt   <= '0;
        end else if (dg_cnt == DG_LAST) begin
            clk_filt <= clk_sync_p1;
            dg_cnt   <= '0;
        end else begin
            dg_cnt   <= dg_cnt + DG_W'(1);
        end
    end

    assign clk_lvl = clk_filt;
`else
    assign clk_lvl = clk_sync_p1;
`endif

    // Edge stage: remember the previous conditioned level.
    always_ff @(posedge clk) begin
        if (rst) begin
            clk_prev <= 1'b1;
        end else begin
            clk_prev <= clk_lvl;
        end
    end

    assign is_h2l   = clk_prev & ~clk_lvl;
    assign dat_sync = dat_sync_p1;

endmodule

// File: rtl/ps2_rx_packet_funcmod.sv
// ---------------------------------------------------------------------------
// ps2_rx_packet_funcmod
// PS/2 device-to-host packet receiver. Collects 1..MAX_BYTES bytes per packet
// (length chosen at run time), checks start/parity/stop bits and drops a
// partial packet after TIMEOUT_CYC cycles without a PS/2 clock falling edge.
//
// Optional build macro: PS2_DEGLITCH_EN (PS/2 clock glitch filter inside
// ps2_edge_sync).
//
// Ports:
//   CLOCK    in   system clock
//   RESET    in   synchronous active-high reset
//   PS2_CLK  in   raw PS/2 clock pin
//   PS2_DAT  in   raw PS/2 data pin
//   iEn      in   receive enable; low aborts and holds the receiver idle
//   iLen     in   bytes per packet, 0 or above MAX_BYTES means MAX_BYTES;
//                 taken at the first start bit of a packet
//   oTrig    out  one-cycle pulse, oData holds a new packet
//   oData    out  packet, first byte in bits [7:0]
//   oErr     out  one-cycle error code (none/parity/frame/timeout)
// ---------------------------------------------------------------------------
module ps2_rx_packet_funcmod
    import ps2_pkg::*;
#(
    parameter int MAX_BYTES    = 4,
    parameter int TIMEOUT_CYC  = TIMEOUT_CYC_DEFAULT,
    parameter int DEGLITCH_CYC = 8
) (
    input  logic                           CLOCK,
    input  logic                           RESET,
    input  logic                           PS2_CLK,
    input  logic                           PS2_DAT,
    input  logic                           iEn,
    input  logic [$clog2(MAX_BYTES+1)-1:0] iLen,
    output logic                           oTrig,
    output logic [8*MAX_BYTES-1:0]         oData,
    output logic [1:0]                     oErr
);

    localparam int LEN_W = $clog2(MAX_BYTES + 1);
    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(MAX_BYTES);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

    logic                   is_h2l;
    logic                   dat_sync;
    state_t                 state;
    logic [2:0]             bit_cnt;
    logic [7:0]             shreg;
    logic                   par_bit;
    logic [LEN_W-1:0]       count;
    logic [LEN_W-1:0]       count_inc;
    logic [LEN_W-1:0]       len;
    logic [8*MAX_BYTES-1:0] slots;
    logic [8*MAX_BYTES-1:0] pkt_next;
    logic [TMO_W-1:0]       tmo_cnt;
    logic                   tmo_run;

    function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] req);
        if (req == '0 || req > LEN_MAX) begin
            return LEN_MAX;
        end
        return req;
    endfunction

    ps2_edge_sync #(
        .DEGLITCH_CYC (DEGLITCH_CYC)
    ) u_sync (
        .clk      (CLOCK),
        .rst      (RESET),
        .ps2_clk  (PS2_CLK),
        .ps2_dat  (PS2_DAT),
        .is_h2l   (is_h2l),
        .dat_sync (dat_sync)
    );

    assign count_inc = count + LEN_W'(1);

    // The inactivity timer only matters while a packet is partly received.
    assign tmo_run = (state != ST_IDLE) || (count != '0);

    // Packet image as it will look once the byte now in shreg is appended:
    // earlier slots, then shreg, zeros above.
    always_comb begin
        pkt_next = '0;
        for (int k = 0; k < MAX_BYTES; k++) begin
            if (LEN_W'(k) < count) begin
                pkt_next[8*k +: 8] = slots[8*k +: 8];
            end else if (LEN_W'(k) == count) begin
                pkt_next[8*k +: 8] = shreg;
            end
        end
    end

    // Receive FSM. Priority: reset, enable low, DONE housekeeping, PS/2 edge,
    // then timeout (so an edge in the expiry cycle still clears the timer).
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state   <= ST_IDLE;
            bit_cnt <= '0;
            count   <= '0;
            len     <= LEN_MAX;
            tmo_cnt <= '0;
            oTrig   <= 1'b0;
            oData   <= '0;
            oErr    <= ERR_NONE;
        end else begin
            oTrig <= 1'b0;
            oErr  <= ERR_NONE;
            if (!iEn) begin
                state   <= ST_IDLE;
                count   <= '0;
                tmo_cnt <= '0;
            end else if (state == ST_DONE) begin
                state   <= ST_IDLE;
                count   <= '0;
                tmo_cnt <= '0;
            end else if (is_h2l) begin
                tmo_cnt <= '0;
                case (state)
                    ST_IDLE: begin
                        if (!dat_sync) begin
                            state   <= ST_DATA;
                            bit_cnt <= '0;
                            if (count == '0) begin
                                len <= clamp_len(iLen);
                            end
                        end
                    end
                    ST_DATA: begin
                        shreg   <= {dat_sync, shreg[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            state <= ST_PARITY;
                        end
                    end
                    ST_PARITY: begin
                        par_bit <= dat_sync;
                        state   <= ST_STOP;
                    end
                    ST_STOP: begin
                        // Parity is checked first so it wins when both bits are bad.
                        if (!odd_parity_ok(shreg, par_bit)) begin
                            oErr  <= ERR_PARITY;
                            state <= ST_IDLE;
                            count <= '0;
                        end else if (!dat_sync) begin
                            oErr  <= ERR_FRAME;
                            state <= ST_IDLE;
                            count <= '0;
                        end else begin
                            for (int k = 0; k < MAX_BYTES; k++) begin
                                if (count == LEN_W'(k)) begin
                                    slots[8*k +: 8] <= shreg;
                                end
                            end
                            count <= count_inc;
                            if (count_inc == len) begin
                                state <= ST_DONE;
                                oTrig <= 1'b1;
                                oData <= pkt_next;
                            end else begin
                                state <= ST_IDLE;
                            end
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end else if (tmo_run) begin
                if (tmo_cnt == TMO_LAST) begin
                    oErr    <= ERR_TIMEOUT;
                    state   <= ST_IDLE;
                    count   <= '0;
                    tmo_cnt <= '0;
                end else begin
                    tmo_cnt <= tmo_cnt + TMO_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_ps2_rx_packet_funcmod.sv
module tb_ps2_rx_packet_funcmod;

    localparam int MAX_BYTES    = 4;
    localparam int TIMEOUT_CYC  = 300;
    localparam int DEGLITCH_CYC = 8;
    localparam int HALF         = 16;
`ifdef PS2_DEGLITCH_EN
    localparam int LAT = 3 + DEGLITCH_CYC;
`else
    localparam int LAT = 3;
`endif

    logic        CLOCK = 1'b0;
    logic        RESET;
    logic        PS2_CLK;
    logic        PS2_DAT;
    logic        iEn;
    logic [2:0]  iLen;
    logic        oTrig;
    logic [31:0] oData;
    logic [1:0]  oErr;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    int fall_cyc = 0;

    // event monitor state
    int          trig_cnt  = 0;
    int          err_cnt   = 0;
    int          trig_cyc  = 0;
    int          err_cyc   = 0;
    int          long_cnt  = 0;
    int          both_cnt  = 0;
    logic [31:0] trig_data = '0;
    logic [1:0]  last_err  = 2'b00;
    logic        prev_trig = 1'b0;
    logic [1:0]  prev_err  = 2'b00;

    ps2_rx_packet_funcmod #(
        .MAX_BYTES    (MAX_BYTES),
        .TIMEOUT_CYC  (TIMEOUT_CYC),
        .DEGLITCH_CYC (DEGLITCH_CYC)
    ) dut (
        .CLOCK   (CLOCK),
        .RESET   (RESET),
        .PS2_CLK (PS2_CLK),
        .PS2_DAT (PS2_DAT),
        .iEn     (iEn),
        .iLen    (iLen),
        .oTrig   (oTrig),
        .oData   (oData),
        .oErr    (oErr)
    );

    always #5 CLOCK = ~CLOCK;

    always @(posedge CLOCK) cyc <= cyc + 1;

    always @(negedge CLOCK) begin
        if (oTrig === 1'b1) begin
            trig_cnt++;
            trig_cyc  = cyc;
            trig_data = oData;
            if (oErr !== 2'b00) both_cnt++;
            if (prev_trig === 1'b1) long_cnt++;
        end
        if (oErr !== 2'b00) begin
            err_cnt++;
            err_cyc  = cyc;
            last_err = oErr;
            if (prev_err !== 2'b00) long_cnt++;
        end
        prev_trig = oTrig;
        prev_err  = oErr;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge CLOCK);
        #1;
    endtask

    task automatic send_bit(input logic b, input bit glitch);
        PS2_DAT = b;
        if (glitch) begin
            cycles(4);
            PS2_CLK = 1'b0;
            cycles(2);
            PS2_CLK = 1'b1;
            cycles(HALF - 6);
        end else begin
            cycles(HALF);
        end
        PS2_CLK  = 1'b0;
        fall_cyc = cyc;
        cycles(HALF);
        PS2_CLK  = 1'b1;
    endtask

    // bits: start, d[0..7], odd parity, stop; only the first nbits are sent
    task automatic send_frame(input logic [7:0] d, input bit bad_par, input bit bad_stop,
                              input int nbits, input int glitch_at);
        logic [10:0] bits;
        bits = {~bad_stop, (~^d) ^ bad_par, d, 1'b0};
        for (int i = 0; i < nbits; i++) send_bit(bits[i], i == glitch_at);
        PS2_DAT = 1'b1;
    endtask

    task automatic test_reset;
        RESET = 1'b1; iEn = 1'b1; iLen = 3'd3; PS2_CLK = 1'b1; PS2_DAT = 1'b1;
        cycles(4);
        n_cmp++; if (oTrig !== 1'b0) begin n_bad++; $display("FAIL reset_trig: got %0b want 0", oTrig); end
        n_cmp++; if (oData !== 32'h0) begin n_bad++; $display("FAIL reset_data: got %h want 00000000", oData); end
        n_cmp++; if (oErr !== 2'b00) begin n_bad++; $display("FAIL reset_err: got %b want 00", oErr); end
        RESET = 1'b0;
        cycles(4);
    endtask

    task automatic test_len3;
        int t0, e0;
        t0 = trig_cnt; e0 = err_cnt;
        iLen = 3'd3;
        send_frame(8'h08, 0, 0, 11, -1);
        send_frame(8'h10, 0, 0, 11, -1);
        n_cmp++; if (trig_cnt - t0 !== 0) begin n_bad++; $display("FAIL len3_early_trig: got %0d want 0", trig_cnt - t0); end
        send_frame(8'hF0, 0, 0, 11, -1);
        n_cmp++; if (trig_cnt - t0 !== 1) begin n_bad++; $display("FAIL len3_trig_count: got %0d want 1", trig_cnt - t0); end
        n_cmp++; if (trig_data !== 32'h00F01008) begin n_bad++; $display("FAIL len3_data: got %h want 00F01008", trig_data); end
        n_cmp++; if (trig_cyc !== fall_cyc + LAT) begin n_bad++; $display("FAIL len3_trig_latency: got %0d want %0d", trig_cyc, fall_cyc + LAT); end
        n_cmp++; if (err_cnt - e0 !== 0) begin n_bad++; $display("FAIL len3_err: got %0d want 0", err_cnt - e0); end
        cycles(40);
        n_cmp++; if (oData !== 32'h00F01008) begin n_bad++; $display("FAIL len3_hold: got %h want 00F01008", oData); end
    endtask

    task automatic test_len4_clamp;
        int t0, e0;
        t0 = trig_cnt; e0 = err_cnt;
        iLen = 3'd4;
        send_frame(8'h08, 0, 0, 11, -1);
        send_frame(8'h01, 0, 0, 11, -1);
        send_frame(8'hFF, 0, 0, 11, -1);
        send_frame(8'h01, 0, 0, 11, -1);
        n_cmp++; if (trig_cnt - t0 !== 1) begin n_bad++; $display("FAIL len4_trig_count: got %0d want 1", trig_cnt - t0); end
        n_cmp++; if (trig_data !== 32'h01FF0108) begin n_bad++; $display("FAIL len4_data: got %h want 01FF0108", trig_data); end
        // iLen=0 clamps to 4; the later change to 1 is ignored mid-packet
        t0 = trig_cnt;
        iLen = 3'd0;
        send_frame(8'h11, 0, 0, 11, -1);
        iLen = 3'd1;
        send_frame(8'h22, 0, 0, 11, -1);
        send_frame(8'h33, 0, 0, 11, -1);
        n_cmp++; if (trig_cnt - t0 !== 0) begin n_bad++; $display("FAIL clamp_early_trig: got %0d want 0", trig_cnt - t0); end
        send_frame(8'h44, 0, 0, 11, -1);
        n_cmp++; if (trig_cnt - t0 !== 1) begin n_bad++; $display("FAIL clamp_trig_count: got %0d want 1", trig_cnt - t0); end
        n_cmp++; if (trig_data !== 32'h44332211) begin n_bad++; $display("FAIL clamp_data: got %h want 44332211", trig_data); end
        n_cmp++; if (err_cnt - e0 !== 0) begin n_bad++; $display("FAIL len4_err: got %0d want 0", err_cnt - e0); end
    endtask

    task automatic test_parity_err;
        int t0, e0;
        t0 = trig_cnt; e0 = err_cnt;
        iLen = 3'd3;
        send_frame(8'h12, 0, 0, 11, -1);
        send_frame(8'h34, 1, 0, 11, -1);
        n_cmp++; if (err_cnt - e0 !== 1) begin n_bad++; $display("FAIL par_err_count: got %0d want 1", err_cnt - e0); end
        n_cmp++; if (last_err !== 2'b01) begin n_bad++; $display("FAIL par_err_code: got %b want 01", last_err); end
        n_cmp++; if (err_cyc !== fall_cyc + LAT) begin n_bad++; $display("FAIL par_err_latency: got %0d want %0d", err_cyc, fall_cyc + LAT); end
        n_cmp++; if (trig_cnt - t0 !== 0) begin n_bad++; $display("FAIL par_no_trig: got %0d want 0", trig_cnt - t0); end
        n_cmp++; if (oData !== 32'h44332211) begin n_bad++; $display("FAIL par_data_kept: got %h want 44332211", oData); end
        send_frame(8'hAA, 0, 0, 11, -1);
        send_frame(8'h55, 0, 0, 11, -1);
        send_frame(8'h0F, 0, 0, 11, -1);
        n_cmp++; if (trig_cnt - t0 !== 1) begin n_bad++; $display("FAIL par_recover_trig: got %0d want 1", trig_cnt - t0); end
        n_cmp++; if (trig_data !== 32'h000F55AA) begin n_bad++; $display("FAIL par_recover_data: got %h want 000F55AA", trig_data); end
    endtask

    task automatic test_timeout;
        int t0, e0;
        t0 = trig_cnt; e0 = err_cnt;
        iLen = 3'd2;
        send_frame(8'hE7, 0, 0, 6, -1);
        cycles(TIMEOUT_CYC + LAT + 20);
        n_cmp++; if (err_cnt - e0 !== 1) begin n_bad++; $display("FAIL tmo_err_count: got %0d want 1", err_cnt - e0); end
        n_cmp++; if (last_err !== 2'b11) begin n_bad++; $display("FAIL tmo_err_code: got %b want 11", last_err); end
        n_cmp++; if (err_cyc !== fall_cyc + LAT + TIMEOUT_CYC) begin n_bad++; $display("FAIL tmo_latency: got %0d want %0d", err_cyc, fall_cyc + LAT + TIMEOUT_CYC); end
        n_cmp++; if (trig_cnt - t0 !== 0) begin n_bad++; $display("FAIL tmo_no_trig: got %0d want 0", trig_cnt - t0); end
        send_frame(8'h81, 0, 0, 11, -1);
        send_frame(8'h7E, 0, 0, 11, -1);
        n_cmp++; if (trig_cnt - t0 !== 1) begin n_bad++; $display("FAIL tmo_recover_trig: got %0d want 1", trig_cnt - t0); end
        n_cmp++; if (trig_data !== 32'h00007E81) begin n_bad++; $display("FAIL tmo_recover_data: got %h want 00007E81", trig_data); end
        n_cmp++; if (err_cnt - e0 !== 1) begin n_bad++; $display("FAIL tmo_recover_err: got %0d want 1", err_cnt - e0); end
    endtask

    task automatic test_frame_err;
        int t0, e0;
        t0 = trig_cnt; e0 = err_cnt;
        iLen = 3'd1;
        send_frame(8'h5A, 0, 1, 11, -1);
        n_cmp++; if (err_cnt - e0 !== 1) begin n_bad++; $display("FAIL frame_err_count: got %0d want 1", err_cnt - e0); end
        n_cmp++; if (last_err !== 2'b10) begin n_bad++; $display("FAIL frame_err_code: got %b want 10", last_err); end
        n_cmp++; if (err_cyc !== fall_cyc + LAT) begin n_bad++; $display("FAIL frame_err_latency: got %0d want %0d", err_cyc, fall_cyc + LAT); end
        n_cmp++; if (oData !== 32'h00007E81) begin n_bad++; $display("FAIL frame_data_kept: got %h want 00007E81", oData); end
        send_frame(8'h5A, 1, 1, 11, -1);
        n_cmp++; if (last_err !== 2'b01) begin n_bad++; $display("FAIL both_faults_code: got %b want 01", last_err); end
        n_cmp++; if (trig_cnt - t0 !== 0) begin n_bad++; $display("FAIL frame_no_trig: got %0d want 0", trig_cnt - t0); end
        send_frame(8'h5A, 0, 0, 11, -1);
        n_cmp++; if (trig_data !== 32'h0000005A) begin n_bad++; $display("FAIL len1_data: got %h want 0000005A", trig_data); end
        n_cmp++; if (trig_cnt - t0 !== 1) begin n_bad++; $display("FAIL len1_trig: got %0d want 1", trig_cnt - t0); end
    endtask

    task automatic test_disable;
        int t0, e0;
        t0 = trig_cnt; e0 = err_cnt;
        iLen = 3'd2;
        send_frame(8'hC3, 0, 0, 11, -1);
        send_frame(8'h99, 0, 0, 5, -1);
        iEn = 1'b0;
        cycles(4);
        send_frame(8'hFF, 0, 0, 11, -1);
        cycles(4);
        iEn = 1'b1;
        cycles(TIMEOUT_CYC + LAT + 20);
        n_cmp++; if (err_cnt - e0 !== 0) begin n_bad++; $display("FAIL dis_no_err: got %0d want 0", err_cnt - e0); end
        n_cmp++; if (trig_cnt - t0 !== 0) begin n_bad++; $display("FAIL dis_no_trig: got %0d want 0", trig_cnt - t0); end
        send_frame(8'hC3, 0, 0, 11, -1);
        send_frame(8'h3C, 0, 0, 11, -1);
        n_cmp++; if (trig_cnt - t0 !== 1) begin n_bad++; $display("FAIL dis_recover_trig: got %0d want 1", trig_cnt - t0); end
        n_cmp++; if (trig_data !== 32'h00003CC3) begin n_bad++; $display("FAIL dis_recover_data: got %h want 00003CC3", trig_data); end
    endtask

    task automatic test_glitch;
        int t0, e0;
        t0 = trig_cnt; e0 = err_cnt;
        iLen = 3'd1;
        send_frame(8'h00, 0, 0, 11, 3);
        cycles(20);
`ifdef PS2_DEGLITCH_EN
        n_cmp++; if (trig_cnt - t0 !== 1) begin n_bad++; $display("FAIL glitch_trig: got %0d want 1", trig_cnt - t0); end
        n_cmp++; if (trig_data !== 32'h00000000) begin n_bad++; $display("FAIL glitch_data: got %h want 00000000", trig_data); end
        n_cmp++; if (err_cnt - e0 !== 0) begin n_bad++; $display("FAIL glitch_err: got %0d want 0", err_cnt - e0); end
`else
        n_cmp++; if (trig_cnt - t0 !== 0) begin n_bad++; $display("FAIL glitch_trig: got %0d want 0", trig_cnt - t0); end
        n_cmp++; if (err_cnt - e0 !== 1) begin n_bad++; $display("FAIL glitch_err_count: got %0d want 1", err_cnt - e0); end
        n_cmp++; if (last_err !== 2'b01) begin n_bad++; $display("FAIL glitch_err_code: got %b want 01", last_err); end
`endif
    endtask

    task automatic test_pulse_rules;
        n_cmp++; if (long_cnt !== 0) begin n_bad++; $display("FAIL pulse_width: got %0d long pulses want 0", long_cnt); end
        n_cmp++; if (both_cnt !== 0) begin n_bad++; $display("FAIL trig_with_err: got %0d want 0", both_cnt); end
    endtask

    initial begin
        test_reset();
        test_len3();
        test_len4_clamp();
        test_parity_err();
        test_timeout();
        test_frame_err();
        test_disable();
        test_glitch();
        test_pulse_rules();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
